// File: rtl/bus_pkg.sv
// Shared types and constants for the single-outstanding bus initiator.
package bus_pkg;

   localparam int unsigned BUS_AW   = 32;
   localparam int unsigned BUS_DW   = 32;
   localparam int unsigned REGION_W = 2;

   // Region field decode: 2'b10 -> ce0, 2'b11 -> ce1, 2'b0x -> cs
   localparam logic [REGION_W-1:0] REGION_CE0     = 2'b10;
   localparam logic [REGION_W-1:0] REGION_CE1     = 2'b11;
   localparam logic [REGION_W-1:0] REGION_CS      = 2'b00;
   localparam logic [REGION_W-1:0] REGION_CS_MASK = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Response payload held while rsp_valid waits for rsp_ready
   typedef struct packed {
      logic [BUS_DW-1:0]   rdata;
      logic                err;
      logic [REGION_W-1:0] region;
   } rsp_t;

   // cs owns the whole lower half of the map, so only the top region bit matters
   function automatic logic region_is_cs(input logic [REGION_W-1:0] region);
      return (region & REGION_CS_MASK) == REGION_CS;
   endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Requester, bus and response signals of the bus initiator, grouped for port passing.
interface bus_initiator_if
   import bus_pkg::*;
#(
   parameter int unsigned AW = BUS_AW,
   parameter int unsigned DW = BUS_DW
);

   // requester side
   logic                req_valid;
   logic                req_ready;
   logic [AW-1:0]       req_addr;
   logic                req_we;
   logic [DW-1:0]       req_wdata;

   // bus side toward the region decoder
   logic                en;
   logic [AW-1:0]       addr;
   logic                we;
   logic [DW-1:0]       wdata;
   logic                ack;
   logic [DW-1:0]       rdata;

   // response side
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DW-1:0]       rsp_rdata;
   logic                rsp_err;
   logic [REGION_W-1:0] rsp_region;

   // initiator view
   modport master (
      input  req_valid, req_addr, req_we, req_wdata,
      output req_ready,
      output en, addr, we, wdata,
      input  ack, rdata,
      output rsp_valid, rsp_rdata, rsp_err, rsp_region,
      input  rsp_ready
   );

   // requester plus target view
   modport slave (
      output req_valid, req_addr, req_we, req_wdata,
      input  req_ready,
      input  en, addr, we, wdata,
      output ack, rdata,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_region,
      output rsp_ready
   );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Counts cycles spent waiting for ack; flags the last allowed cycle.
module bus_timeout_ctr #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam int unsigned   CW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Cleared on request accept, so it can never reach wrap while enabled
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // TIMEOUT of 0 disables the timeout entirely
   generate
      if (TIMEOUT == 0) begin : g_never
         assign expired_c = 1'b0;
      end else begin : g_count
         assign expired_c = enable && (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: one request in, one bus cycle out, one response back.
module bus_initiator
   import bus_pkg::*;
#(
   parameter int unsigned AW      = BUS_AW,
   parameter int unsigned DW      = BUS_DW,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   bus_initiator_if.master bif,
   output logic            stray_ack
);

   // AW/DW must match the connected interface; DW must not exceed BUS_DW
   state_t state;
   rsp_t   rsp_q;
   logic   accept_c;
   logic   in_bus_c;
   logic   expired_c;

   assign accept_c = (state == IDLE) && bif.req_valid && bif.req_ready;
   assign in_bus_c = (state == BUS);

   bus_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept_c),
      .enable    (in_bus_c),
      .expired_c (expired_c)
   );

   assign bif.rsp_rdata  = DW'(rsp_q.rdata);
   assign bif.rsp_err    = rsp_q.err;
   assign bif.rsp_region = rsp_q.region;

   // Transaction FSM; every bus and response output is a flop so en is never X
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bif.req_ready <= 1'b0;
         bif.en        <= 1'b0;
         bif.addr      <= '0;
         bif.we        <= 1'b0;
         bif.wdata     <= '0;
         bif.rsp_valid <= 1'b0;
         rsp_q         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               bif.req_ready <= 1'b1;
               if (accept_c) begin
                  bif.req_ready <= 1'b0;
                  bif.en        <= 1'b1;
                  bif.addr      <= bif.req_addr;
                  bif.we        <= bif.req_we;
                  bif.wdata     <= bif.req_wdata;
                  state         <= BUS;
               end
            end
            BUS: begin
               // ack takes priority over a timeout landing on the same cycle
               if (bif.ack) begin
                  bif.en        <= 1'b0;
                  bif.rsp_valid <= 1'b1;
                  rsp_q.rdata   <= bif.we ? '0 : BUS_DW'(bif.rdata);
                  rsp_q.err     <= 1'b0;
                  rsp_q.region  <= bif.addr[AW-1 -: REGION_W];
                  state         <= RESP;
               end else if (expired_c) begin
                  bif.en        <= 1'b0;
                  bif.rsp_valid <= 1'b1;
                  rsp_q.rdata   <= '0;
                  rsp_q.err     <= 1'b1;
                  rsp_q.region  <= bif.addr[AW-1 -: REGION_W];
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bif.rsp_ready) begin
                  bif.rsp_valid <= 1'b0;
                  bif.req_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               bif.en        <= 1'b0;
               bif.rsp_valid <= 1'b0;
               bif.req_ready <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

   // Sticky flag for any ack arriving while no bus cycle is open
   always_ff @(posedge clk) begin
      if (rst) begin
         stray_ack <= 1'b0;
      end else if (bif.ack && (state != BUS)) begin
         stray_ack <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_initiator.sv
// Randomised scoreboard bench for bus_initiator with a behavioural target model.
module tb_bus_initiator;
   import bus_pkg::*;

   localparam int unsigned AW      = 32;
   localparam int unsigned DW      = 32;
   localparam int unsigned TIMEOUT = 16;
   localparam int          NO_ACK  = 1000;

   typedef struct {
      int          d;      // ack delay in cycles after en rises
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          len;    // expected number of en-high cycles
   } bus_item_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  region;
   } exp_rsp_t;

   logic clk         = 1'b0;
   logic rst         = 1'b1;
   logic stray_ack;
   logic tgt_ack     = 1'b0;
   logic stray_pulse = 1'b0;

   always #5 clk = ~clk;

   bus_initiator_if #(.AW(AW), .DW(DW)) bif ();
   assign bif.ack = tgt_ack | stray_pulse;

   bus_initiator #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bif       (bif),
      .stray_ack (stray_ack)
   );

   int        tests       = 0;
   int        fails       = 0;
   int        cyc         = 0;
   int        accept_cyc  = 0;
   int        last_en_cyc = 0;
   bit        tgt_busy    = 1'b0;
   int        stall_n     = 0;
   bit        rand_ready  = 1'b0;
   bus_item_t tgt_q[$];
   exp_rsp_t  exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name, input string msg);
      tests++;
      fails++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   // Reference: ack delay d at or beyond TIMEOUT means the initiator gives up first
   function automatic bit ref_timed_out(input int d);
      return (TIMEOUT != 0) && (d >= int'(TIMEOUT));
   endfunction

   function automatic int ref_len(input int d);
      return ref_timed_out(d) ? int'(TIMEOUT) : d + 1;
   endfunction

   function automatic exp_rsp_t ref_rsp(input logic [31:0] a, input logic w,
                                        input logic [31:0] rd, input int d);
      exp_rsp_t r;
      r.err    = ref_timed_out(d);
      r.rdata  = (r.err || w) ? 32'h0 : rd;
      r.region = a[31:30];
      return r;
   endfunction

   // Present one request and hold it until accepted; abort_len!=0 marks a reset-aborted one
   task automatic send(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] rd, input int d, input int abort_len);
      bus_item_t it;
      int        waited;
      waited        = 0;
      bif.req_valid = 1'b1;
      bif.req_addr  = a;
      bif.req_we    = w;
      bif.req_wdata = wd;
      while ((bif.req_ready !== 1'b1) && (waited < 200)) begin
         @(negedge clk);
         waited++;
      end
      if (bif.req_ready !== 1'b1) begin
         note_fail("req_accept_timeout", "req_ready never rose");
         bif.req_valid = 1'b0;
         return;
      end
      chk("single_outstanding_rsp", 64'(exp_q.size()), 64'd0);
      chk("single_outstanding_bus", 64'(tgt_busy), 64'd0);
      it = '{d: d, rdata: rd, addr: a, we: w, wdata: wd,
             len: (abort_len != 0) ? abort_len : ref_len(d)};
      tgt_q.push_back(it);
      if (abort_len == 0) exp_q.push_back(ref_rsp(a, w, rd, d));
      accept_cyc = cyc;
      @(negedge clk);
      bif.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (((exp_q.size() != 0) || tgt_busy || (bif.rsp_valid === 1'b1)) && (n < 300)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) note_fail("drain_timeout", "responses still pending");
   endtask

   // Target model: acks d cycles after en rises and checks the bus phase
   initial begin : target
      bus_item_t cur;
      int        k;
      int        nen;
      k   = 0;
      nen = 0;
      forever begin
         @(negedge clk);
         tgt_ack   = 1'b0;
         bif.rdata = $urandom;
         if (bif.en === 1'b1) begin
            if (!tgt_busy) begin
               if (tgt_q.size() == 0) begin
                  note_fail("unexpected_en", "en high with no accepted request");
               end else begin
                  cur      = tgt_q.pop_front();
                  tgt_busy = 1'b1;
                  k        = 0;
                  nen      = 0;
                  chk("en_latency", 64'(cyc), 64'(accept_cyc + 1));
               end
            end
            if (tgt_busy) begin
               chk("bus_addr", 64'(bif.addr), 64'(cur.addr));
               chk("bus_we", 64'(bif.we), 64'(cur.we));
               chk("bus_wdata", 64'(bif.wdata), 64'(cur.wdata));
               nen++;
               last_en_cyc = cyc;
               if (k == cur.d) begin
                  tgt_ack   = 1'b1;
                  bif.rdata = cur.rdata;
               end
               k++;
            end
         end else if (tgt_busy) begin
            tgt_busy = 1'b0;
            chk("en_cycles", 64'(nen), 64'(cur.len));
         end
      end
   end

   // Response monitor: drives rsp_ready, checks hold stability and scoreboard order
   initial begin : monitor
      bit          seen;
      bit          ready;
      logic [31:0] s_rdata;
      logic        s_err;
      logic [1:0]  s_region;
      exp_rsp_t    e;
      seen          = 1'b0;
      bif.rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bif.rsp_valid === 1'b1) begin
            if (!seen) begin
               seen     = 1'b1;
               s_rdata  = bif.rsp_rdata;
               s_err    = bif.rsp_err;
               s_region = bif.rsp_region;
               chk("rsp_latency", 64'(cyc), 64'(last_en_cyc + 1));
            end else begin
               chk("rsp_hold_rdata", 64'(bif.rsp_rdata), 64'(s_rdata));
               chk("rsp_hold_err", 64'(bif.rsp_err), 64'(s_err));
               chk("rsp_hold_region", 64'(bif.rsp_region), 64'(s_region));
            end
            chk("req_ready_in_resp", 64'(bif.req_ready), 64'd0);
            chk("en_in_resp", 64'(bif.en), 64'd0);
         end else begin
            seen = 1'b0;
         end
         if (stall_n > 0) begin
            ready = 1'b0;
            if (bif.rsp_valid === 1'b1) stall_n--;
         end else if (rand_ready) begin
            ready = ($urandom_range(0, 3) != 0);
         end else begin
            ready = 1'b1;
         end
         bif.rsp_ready = ready;
         if ((bif.rsp_valid === 1'b1) && ready) begin
            seen = 1'b0;
            if (exp_q.size() == 0) begin
               note_fail("unexpected_rsp", "response with empty scoreboard");
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", 64'(bif.rsp_rdata), 64'(e.rdata));
               chk("rsp_err", 64'(bif.rsp_err), 64'(e.err));
               chk("rsp_region", 64'(bif.rsp_region), 64'(e.region));
            end
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: run did not complete, %0d tests run", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        w;
      int          d;

      bif.req_valid = 1'b0;
      bif.req_addr  = '0;
      bif.req_we    = 1'b0;
      bif.req_wdata = '0;
      rst           = 1'b1;
      repeat (3) @(negedge clk);

      chk("reset_en", 64'(bif.en), 64'd0);
      chk("reset_we", 64'(bif.we), 64'd0);
      chk("reset_addr", 64'(bif.addr), 64'd0);
      chk("reset_wdata", 64'(bif.wdata), 64'd0);
      chk("reset_rsp_valid", 64'(bif.rsp_valid), 64'd0);
      chk("reset_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
      chk("reset_rsp_err", 64'(bif.rsp_err), 64'd0);
      chk("reset_rsp_region", 64'(bif.rsp_region), 64'd0);
      chk("reset_stray_ack", 64'(stray_ack), 64'd0);

      rst = 1'b0;
      @(negedge clk);
      chk("req_ready_after_reset", 64'(bif.req_ready), 64'd1);

      // directed: read, write, timeout, ack on last cycle, write timeout
      send(32'h8000_0000, 1'b0, 32'h0,         32'hDEAD_BEEF, 1,      0);
      send(32'h4000_0010, 1'b1, 32'h0000_1234, 32'h5A5A_5A5A, 0,      0);
      send(32'hC000_0000, 1'b0, 32'h0,         32'hCAFE_F00D, NO_ACK, 0);
      send(32'h0000_0020, 1'b0, 32'h0,         32'h0BAD_CAFE, 15,     0);
      send(32'h8000_0040, 1'b1, 32'h0000_AAAA, 32'h7777_7777, 16,     0);
      wait_idle();

      // response held off for 5 cycles while the next request waits
      stall_n = 5;
      send(32'h4000_0000, 1'b0, 32'h0,         32'h1111_2222, 2, 0);
      send(32'hC000_0004, 1'b1, 32'h0000_BEEF, 32'h0,         0, 0);
      wait_idle();

      // back-to-back reads to ce1 then cs
      send(32'hC000_0000, 1'b0, 32'h0, 32'h3333_3333, 0, 0);
      send(32'h0000_0008, 1'b0, 32'h0, 32'h4444_4444, 0, 0);
      wait_idle();

      // reset during the third bus cycle, then an ack with no bus cycle open
      send(32'h8000_0100, 1'b0, 32'h0, 32'h5555_5555, NO_ACK, 3);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_en", 64'(bif.en), 64'd0);
      chk("abort_rsp_valid", 64'(bif.rsp_valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_req_ready", 64'(bif.req_ready), 64'd1);
      chk("stray_before_pulse", 64'(stray_ack), 64'd0);
      stray_pulse = 1'b1;
      @(negedge clk);
      stray_pulse = 1'b0;
      chk("stray_set", 64'(stray_ack), 64'd1);

      // randomised traffic with random response back-pressure
      rand_ready = 1'b1;
      repeat (150) begin
         a  = $urandom;
         wd = $urandom;
         rd = $urandom;
         w  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       d = 0;
            1:       d = 1;
            2:       d = int'($urandom_range(2, 14));
            3:       d = 15;
            4:       d = 16;
            default: d = NO_ACK;
         endcase
         send(a, w, wd, rd, d, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      chk("stray_sticky", 64'(stray_ack), 64'd1);
      chk("tgt_queue_empty", 64'(tgt_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
